// File: rtl/oversampling_detector_pkg.sv
// Shared types and sizes for the oversampling level-change detector.
//   DEFAULT_WIDTH : default oversampled word width (samples per parallel word)
//   IDX_W         : width of a sample index for the default word width
//   word_t        : one oversampled word at the default width
//   bit_idx_t     : one sample index at the default width
package oversampling_detector_pkg;

   localparam int unsigned DEFAULT_WIDTH = 64;
   localparam int unsigned IDX_W         = 6;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;
   typedef logic [IDX_W-1:0]         bit_idx_t;

endpackage : oversampling_detector_pkg

// File: rtl/oversampling_first_set_encoder.sv
// Combinational lowest-set-bit finder.
// Ports:
//   i_vec : WIDTH-bit vector to search
//   o_idx : index of the lowest set bit (0 when none is set)
//   o_any : high when at least one bit of i_vec is set
module oversampling_first_set_encoder #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0]         i_vec,
   output logic [$clog2(WIDTH)-1:0] o_idx,
   output logic                     o_any
);

   localparam int unsigned IDX_W = $clog2(WIDTH);

   // Scan from the top down so the last hit is the lowest index.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = IDX_W'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule : oversampling_first_set_encoder

// File: rtl/oversampling_iserdes_detector.sv
// Detects net level changes in a stream of oversampled parallel words and
// reports the index of the first sample at the new level.
// Optional build macro:
//   OVERSAMPLING_DETECTOR_INPUT_REG_EN : adds an input register (latency 3
//                                        instead of 2)
// Ports:
//   CLK_PARALLEL  : parallel-word clock, all logic on the rising edge
//   RESET_N       : asynchronous active-low reset
//   PARALLEL_IN   : oversampled word, bit 0 oldest, bit WIDTH-1 newest
//   CHANGED_FLAG  : one-cycle pulse per reported level change
//   CHANGED_BIT   : index of the first changed sample (0 when no flag)
//   CHANGED_VALUE : new level (0 when no flag)
module oversampling_iserdes_detector
   import oversampling_detector_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                     CLK_PARALLEL,
   input  logic                     RESET_N,
   input  logic [WIDTH-1:0]         PARALLEL_IN,
   output logic                     CHANGED_FLAG,
   output logic [$clog2(WIDTH)-1:0] CHANGED_BIT,
   output logic                     CHANGED_VALUE
);

   logic [WIDTH-1:0]         w_word;
   logic                     w_word_vld;
   logic [$clog2(WIDTH)-1:0] w_idx;
   logic                     w_any;

   logic                     r_state;
   logic                     r_primed;
   logic [WIDTH-1:0]         r_s1_diff;
   logic                     r_s1_chg;
   logic                     r_s1_val;

`ifdef OVERSAMPLING_DETECTOR_INPUT_REG_EN
   logic [WIDTH-1:0] r_in;
   logic             r_in_vld;

   // Input register; r_in_vld keeps the reset value of r_in from priming STATE.
   always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
      if (!RESET_N) begin
         r_in     <= '0;
         r_in_vld <= 1'b0;
      end else begin
         r_in     <= PARALLEL_IN;
         r_in_vld <= 1'b1;
      end
   end

   assign w_word     = r_in;
   assign w_word_vld = r_in_vld;
`else
   assign w_word     = PARALLEL_IN;
   assign w_word_vld = 1'b1;
`endif

   // Stage 1: level state, difference vector and net-change decision.
   // The first word after reset only primes STATE.
   always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= 1'b0;
         r_primed  <= 1'b0;
         r_s1_diff <= '0;
         r_s1_chg  <= 1'b0;
         r_s1_val  <= 1'b0;
      end else if (w_word_vld) begin
         r_state   <= w_word[WIDTH-1];
         r_primed  <= 1'b1;
         r_s1_diff <= w_word ^ {WIDTH{r_state}};
         r_s1_chg  <= r_primed & (w_word[WIDTH-1] ^ r_state);
         r_s1_val  <= w_word[WIDTH-1];
      end
   end

   oversampling_first_set_encoder #(
      .WIDTH (WIDTH)
   ) u_first_set (
      .i_vec (r_s1_diff),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Stage 2: registered report; index and value are forced to 0 without a flag.
   always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
      if (!RESET_N) begin
         CHANGED_FLAG  <= 1'b0;
         CHANGED_BIT   <= '0;
         CHANGED_VALUE <= 1'b0;
      end else begin
         CHANGED_FLAG  <= r_s1_chg & w_any;
         CHANGED_BIT   <= r_s1_chg ? w_idx : '0;
         CHANGED_VALUE <= r_s1_chg & r_s1_val;
      end
   end

endmodule : oversampling_iserdes_detector

// File: tb/tb_oversampling_iserdes_detector.sv
`timescale 1ns/1ps
module tb_oversampling_iserdes_detector;
   import oversampling_detector_pkg::*;

`ifdef OVERSAMPLING_DETECTOR_INPUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   // Square wave timing in units of 1/6400 ns: 5 ns / 64 samples = 500,
   // half period 2145.23 ns = 13729472.
   localparam longint SAMPLE_U = 500;
   localparam longint HALF_U   = 13729472;
   localparam int     SQ_WORDS = 1810;

   logic     CLK_PARALLEL = 1'b0;
   logic     RESET_N      = 1'b0;
   word_t    PARALLEL_IN  = '0;
   logic     CHANGED_FLAG;
   bit_idx_t CHANGED_BIT;
   logic     CHANGED_VALUE;

   oversampling_iserdes_detector dut (
      .CLK_PARALLEL  (CLK_PARALLEL),
      .RESET_N       (RESET_N),
      .PARALLEL_IN   (PARALLEL_IN),
      .CHANGED_FLAG  (CHANGED_FLAG),
      .CHANGED_BIT   (CHANGED_BIT),
      .CHANGED_VALUE (CHANGED_VALUE)
   );

   always #2.5 CLK_PARALLEL = ~CLK_PARALLEL;

   typedef struct {
      word_t       word;
      logic        flag;
      int unsigned idx;
      logic        val;
      string       name;
   } vec_t;

   typedef struct {
      logic     flag;
      bit_idx_t idx;
      logic     val;
      string    name;
   } exp_t;

   exp_t pipe[$];
   int   total     = 0;
   int   bad       = 0;
   int   obs_flags = 0;

   task automatic check_out(input string name, input logic ef, input bit_idx_t ei, input logic ev);
      total++;
      if (CHANGED_FLAG !== ef || CHANGED_BIT !== ei || CHANGED_VALUE !== ev) begin
         bad++;
         $display("FAIL %s: got flag=%0b bit=%0d val=%0b, want flag=%0b bit=%0d val=%0b",
                  name, CHANGED_FLAG, CHANGED_BIT, CHANGED_VALUE, ef, ei, ev);
      end
      if (CHANGED_FLAG === 1'b1) obs_flags++;
   endtask

   task automatic check_state(input string name, input logic es);
      total++;
      if (dut.r_state !== es) begin
         bad++;
         $display("FAIL %s: got state=%0b, want state=%0b", name, dut.r_state, es);
      end
   endtask

   // Apply one word for one cycle; compare the output owed to the word LAT-1 steps back.
   task automatic step(input word_t w, input logic ef, input int unsigned ei, input logic ev,
                       input string name);
      exp_t e;
      PARALLEL_IN = w;
      @(posedge CLK_PARALLEL);
      #1;
      e.flag = ef;
      e.idx  = bit_idx_t'(ei);
      e.val  = ev;
      e.name = name;
      pipe.push_back(e);
      if (pipe.size() >= LAT) begin
         e = pipe.pop_front();
         check_out(e.name, e.flag, e.idx, e.val);
      end
   endtask

   function automatic logic sq_level(input longint n);
      if (n < 0) return 1'b0;
      return logic'(((n * SAMPLE_U) / HALF_U) % 2);
   endfunction

   vec_t vecs[$];

   initial begin
      word_t       w;
      logic        prev;
      int unsigned first;

      vecs.push_back('{64'h0000_0000_0000_0000, 1'b1,  0, 1'b0, "all_zero_from_one"});
      vecs.push_back('{64'h8000_0000_0000_0000, 1'b1, 63, 1'b1, "top_bit_only"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b1,  0, 1'b0, "fall_at_bit0"});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF0, 1'b1,  4, 1'b1, "rise_at_bit4"});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0,  0, 1'b0, "steady_high"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b1,  0, 1'b0, "fall_again"});
      vecs.push_back('{64'h0000_0000_0000_0F00, 1'b0,  0, 1'b0, "glitch_no_net"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b0,  0, 1'b0, "after_glitch_low"});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FF00, 1'b1,  8, 1'b1, "b2b_rise_bit8"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b1,  0, 1'b0, "b2b_fall_bit0"});
      vecs.push_back('{64'h8000_0000_0000_0001, 1'b1,  0, 1'b1, "b2b_rise_bit0"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b1,  0, 1'b0, "fall_to_low"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b0,  0, 1'b0, "flush_low_0"});
      vecs.push_back('{64'h0000_0000_0000_0000, 1'b0,  0, 1'b0, "flush_low_1"});

      // Reset held with all-ones input: outputs and STATE stay 0.
      RESET_N     = 1'b0;
      PARALLEL_IN = '1;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK_PARALLEL);
         #1;
         check_out("in_reset", 1'b0, '0, 1'b0);
      end
      check_state("state_in_reset", 1'b0);

      // Release; the first word only primes STATE.
      RESET_N = 1'b1;
      step('1, 1'b0, 0, 1'b0, "prime_word");
      for (int i = 0; i < LAT - 2; i++) step('1, 1'b0, 0, 1'b0, "prime_hold");
      check_state("state_after_prime", 1'b1);

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].word, vecs[i].flag, vecs[i].idx, vecs[i].val, vecs[i].name);
      check_state("state_after_table", 1'b0);

      // Reset while a change is in flight: nothing reported afterwards.
      step('1, 1'b0, 0, 1'b0, "inflight_rise");
      RESET_N = 1'b0;
      pipe.delete();
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK_PARALLEL);
         #1;
         check_out("mid_reset", 1'b0, '0, 1'b0);
      end
      check_state("state_mid_reset", 1'b0);
      RESET_N = 1'b1;
      step('1, 1'b0, 0, 1'b0, "reprime_high");
      step('1, 1'b0, 0, 1'b0, "after_reprime");
      step('0, 1'b1, 0, 1'b0, "fall_after_reprime");
      step('0, 1'b0, 0, 1'b0, "post_reset_low_0");
      step('0, 1'b0, 0, 1'b0, "post_reset_low_1");
      step('0, 1'b0, 0, 1'b0, "post_reset_low_2");

      // Square wave starting low from a low STATE.
      obs_flags = 0;
      for (int wi = 0; wi < SQ_WORDS; wi++) begin
         prev  = sq_level(longint'(wi) * 64 - 1);
         first = 0;
         for (int b = 63; b >= 0; b--) begin
            w[b] = sq_level(longint'(wi) * 64 + b);
            if (w[b] != prev) first = b;
         end
         if (w[63] != prev)
            step(w, 1'b1, first, w[63], "square_edge");
         else
            step(w, 1'b0, 0, 1'b0, "square_flat");
      end
      total++;
      if (obs_flags != 4) begin
         bad++;
         $display("FAIL square_flag_count: got %0d flags, want 4", obs_flags);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_oversampling_iserdes_detector
